nzc_search: RTL and testbench



---
 rtl/nzc_pkg.sv | 28 ++
 rtl/nzc_search_if.sv | 30 +++
 rtl/nzc_rom.sv | 36 +++
 rtl/nzc_search.sv | 136 +++++++++++++
 tb/tb_nzc_search.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/nzc_pkg.sv
// Shared constants for the Zadoff-Chu length selector: the ascending prime
// table, the reciprocal rule used to build PREC, and the FSM state encoding.
package nzc_pkg;

  localparam int N_PRIMES = 27;
  localparam int PRIME_W  = 10;

  localparam logic [PRIME_W-1:0] PRIME [N_PRIMES] = '{
    10'd31,  10'd47,  10'd53,  10'd59,  10'd71,  10'd89,  10'd107, 10'd113,
    10'd139, 10'd149, 10'd157, 10'd179, 10'd191, 10'd211, 10'd239, 10'd269,
    10'd283, 10'd293, 10'd317, 10'd359, 10'd383, 10'd431, 10'd449, 10'd479,
    10'd523, 10'd571, 10'd599
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // PREC[i] = ceil(2^(rec_w+4) / PRIME[i]); only ever called with constants.
  function automatic logic [63:0] prec_of(input logic [PRIME_W-1:0] p, input int rec_w);
    logic [63:0] num;
    num = 64'd1 << (rec_w + 4);
    return (num + 64'(p) - 64'd1) / 64'(p);
  endfunction

endpackage

// File: rtl/nzc_search_if.sv
// Request/result bundle between the DMRS parameter front end and nzc_search.
interface nzc_search_if #(
  parameter int MZC_W = 11,
  parameter int REC_W = 30,
  parameter int IDX_W = 5
);
  // Both channels are valid/ready: a transfer happens on a clock edge where
  // valid and ready are both high; the source holds its payload while valid
  // is high and ready is low, and ready never depends on valid.
  logic             in_valid;
  logic             in_ready;
  logic [MZC_W-1:0] mzc;
  logic             strict;
  logic             out_valid;
  logic             out_ready;
  logic [MZC_W-1:0] nzc;
  logic [REC_W-1:0] nzc_rec;
  logic [IDX_W-1:0] idx;
  logic             err;

  modport master (
    output in_valid, mzc, strict, out_ready,
    input  in_ready, out_valid, nzc, nzc_rec, idx, err
  );

  modport slave (
    input  in_valid, mzc, strict, out_ready,
    output in_ready, out_valid, nzc, nzc_rec, idx, err
  );
endinterface

// File: rtl/nzc_rom.sv
// Combinational prime/reciprocal lookup with two read ports: one for the
// per-step trial compare and one for fetching the final result.
module nzc_rom
  import nzc_pkg::*;
#(
  parameter int AW    = 5,
  parameter int REC_W = 30
) (
  input  logic [AW-1:0]      cmp_addr,
  output logic [PRIME_W-1:0] cmp_prime,
  input  logic [AW-1:0]      fetch_addr,
  output logic [PRIME_W-1:0] fetch_prime,
  output logic [REC_W-1:0]   fetch_rec
);

  logic [REC_W-1:0] rec_tab [N_PRIMES];

  for (genvar i = 0; i < N_PRIMES; i++) begin : g_rec
    assign rec_tab[i] = REC_W'(prec_of(PRIME[i], REC_W));
  end

  // Out-of-range addresses read as zero so callers need no extra guard.
  always_comb begin
    cmp_prime   = '0;
    fetch_prime = '0;
    fetch_rec   = '0;
    if (int'(cmp_addr) < N_PRIMES) begin
      cmp_prime = PRIME[cmp_addr];
    end
    if (int'(fetch_addr) < N_PRIMES) begin
      fetch_prime = PRIME[fetch_addr];
      fetch_rec   = rec_tab[fetch_addr];
    end
  end

endmodule

// File: rtl/nzc_search.sv
// Fixed-latency binary search over the prime table: picks the largest prime
// below (strict) or not above mzc and returns it with reciprocal and index.
module nzc_search
  import nzc_pkg::*;
#(
  parameter int MZC_W = 11,
  parameter int REC_W = 30
) (
  input  logic         clk,
  input  logic         rst,
  nzc_search_if.slave  bus,
  output state_t       dbg_state
);

  localparam int IDX_W = $clog2(N_PRIMES);
  localparam int STEPS = $clog2(N_PRIMES + 1);
  localparam int CW    = STEPS;
  localparam int BW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  state_t           state_q, state_d;
  logic [MZC_W-1:0] mzc_q;
  logic             strict_q;
  logic [CW-1:0]    c_q, c_d;
  logic [BW-1:0]    b_q, b_d;
  logic             accept, load;

  logic [CW-1:0]      trial, c_step, cmp_addr, fetch_addr;
  logic               trial_in, hit;
  logic [PRIME_W-1:0] cmp_prime, fetch_prime;
  logic [REC_W-1:0]   fetch_rec;
  logic [MZC_W-1:0]   p_ext;

  logic [MZC_W-1:0] nzc_q;
  logic [REC_W-1:0] rec_q;
  logic [IDX_W-1:0] idx_q;
  logic             err_q;

  nzc_rom #(.AW(CW), .REC_W(REC_W)) u_rom (
    .cmp_addr    (cmp_addr),
    .cmp_prime   (cmp_prime),
    .fetch_addr  (fetch_addr),
    .fetch_prime (fetch_prime),
    .fetch_rec   (fetch_rec)
  );

  // One search step: try setting bit b of the count; keep it if the prime at
  // that 1-based position still satisfies the condition.
  always_comb begin
    trial    = c_q | (CW'(1) << b_q);
    trial_in = int'(trial) <= N_PRIMES;
    cmp_addr = trial_in ? trial - CW'(1) : '0;
    p_ext    = MZC_W'(cmp_prime);
    hit      = trial_in && (strict_q ? (p_ext < mzc_q) : (p_ext <= mzc_q));
    c_step   = hit ? trial : c_q;
    // c_step == 0 wraps to an out-of-range address, which the ROM reads as 0.
    fetch_addr = c_step - CW'(1);
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    b_d     = b_q;
    accept  = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          c_d     = '0;
          b_d     = BW'(STEPS - 1);
          state_d = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        c_d = c_step;
        b_d = b_q - BW'(1);
        if (b_q == '0) begin
          load    = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mzc_q    <= '0;
      strict_q <= 1'b0;
      c_q      <= '0;
      b_q      <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      b_q     <= b_d;
      if (accept) begin
        mzc_q    <= bus.mzc;
        strict_q <= bus.strict;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nzc_q <= '0;
      rec_q <= '0;
      idx_q <= '0;
      err_q <= 1'b0;
    end else if (load) begin
      if (c_step == '0) begin
        nzc_q <= '0;
        rec_q <= '0;
        idx_q <= '0;
        err_q <= 1'b1;
      end else begin
        nzc_q <= MZC_W'(fetch_prime);
        rec_q <= fetch_rec;
        idx_q <= IDX_W'(c_step - CW'(1));
        err_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.nzc       = nzc_q;
  assign bus.nzc_rec   = rec_q;
  assign bus.idx       = idx_q;
  assign bus.err       = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_nzc_search.sv
// Bench for nzc_search: directed table corners, back-pressure, mid-search
// reset and random requests against a linear-scan reference model.
module tb_nzc_search;
  import nzc_pkg::*;

  localparam int STEPS = 5;
  localparam int RW    = 47;

  logic   clk;
  logic   rst;
  state_t dbg_state;

  nzc_search_if #(.MZC_W(11), .REC_W(30), .IDX_W(5)) bus ();

  nzc_search #(.MZC_W(11), .REC_W(30)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  int primes [27] = '{31, 47, 53, 59, 71, 89, 107, 113, 139, 149, 157, 179, 191,
                      211, 239, 269, 283, 293, 317, 359, 383, 431, 449, 479, 523,
                      571, 599};

  logic [RW-1:0] exp_q [$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: scan the table from the top, first prime meeting the rule wins.
  function automatic logic [RW-1:0] model(input int m, input bit s);
    logic [63:0] rec;
    for (int i = 26; i >= 0; i--) begin
      if (s ? (primes[i] < m) : (primes[i] <= m)) begin
        rec = ((64'd1 << 34) + 64'(primes[i]) - 64'd1) / 64'(primes[i]);
        return {1'b0, 5'(i), 11'(primes[i]), 30'(rec)};
      end
    end
    return '0 | (RW'(1) << (RW - 1));
  endfunction

  function automatic logic [RW-1:0] observed();
    return {bus.err, bus.idx, bus.nzc, bus.nzc_rec};
  endfunction

  // driver: one full transaction, holding out_ready low for 'hold' cycles
  task automatic do_req(input int m, input bit s, input int hold);
    logic [RW-1:0] exp;
    int n;
    exp_q.push_back(model(m, s));
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.mzc      = 11'(m);
    bus.strict   = s;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.mzc      = 11'($urandom_range(0, 2047));
    n = 1;
    while (!bus.out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("latency", 64'(n), 64'(STEPS + 1));
    exp = exp_q.pop_front();
    check("err", 64'(bus.err), 64'(exp[46]));
    check("idx", 64'(bus.idx), 64'(exp[45:41]));
    check("nzc", 64'(bus.nzc), 64'(exp[40:30]));
    check("nzc_rec", 64'(bus.nzc_rec), 64'(exp[29:0]));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.mzc      = 11'd5;
      @(negedge clk);
      check("hold_valid", 64'(bus.out_valid), 64'd1);
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
      check("hold_data", 64'(observed()), 64'(exp));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("ready_after_done", 64'(bus.in_ready), 64'd1);
    check("valid_after_done", 64'(bus.out_valid), 64'd0);
    check("data_held", 64'(observed()), 64'(exp));
  endtask

  initial begin
    int m;
    int k;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.mzc       = '0;
    bus.strict    = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_data", 64'(observed()), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));

    do_req(36, 1'b0, 0);
    check("rec_of_31", 64'(bus.nzc_rec), 64'h21084211);
    do_req(47, 1'b0, 0);
    do_req(47, 1'b1, 0);
    do_req(30, 1'b0, 0);
    do_req(31, 1'b1, 0);
    do_req(2047, 1'b0, 0);
    do_req(600, 1'b1, 0);
    do_req(599, 1'b1, 0);
    do_req(0, 1'b0, 0);
    do_req(72, 1'b0, 10);
    do_req(300, 1'b0, 0);

    // reset during the third SEARCH cycle drops the request in flight
    bus.in_valid = 1'b1;
    bus.mzc      = 11'd100;
    bus.strict   = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_data", 64'(observed()), 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_no_result", 64'(bus.out_valid), 64'd0);
    end
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    do_req(100, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, 26);
        m = primes[k] + $urandom_range(0, 2) - 1;
      end else begin
        m = $urandom_range(0, 2047);
      end
      do_req(m, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
